// File: rtl/display_write_controller.sv
// Display write controller: decodes PicoBlaze port writes into character display
// memory writes and runs a fill engine that clears the screen or the current row.
// CPU character writes always win the single memory write port; the fill engine
// holds its counters and retries on the following cycle.
module display_write_controller #(
  parameter int unsigned ROW_COUNT    = 30,
  parameter int unsigned COL_COUNT    = 80,
  parameter logic [7:0]  ATTR_DEFAULT = 8'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic        write_strobe,
  input  logic [7:0]  write_data,
  output logic [7:0]  read_data,
  output logic [11:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_data,
  output logic        busy
);

  localparam logic [6:0] ColLast = 7'(COL_COUNT - 1);
  localparam logic [4:0] RowLast = 5'(ROW_COUNT - 1);

  localparam logic [7:0] PortRow      = 8'h80;
  localparam logic [7:0] PortAttr     = 8'h81;
  localparam logic [7:0] PortFullFill = 8'h82;
  localparam logic [7:0] PortRowFill  = 8'h83;

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // CPU-visible registers
  logic [4:0]  r_row_reg;
  logic [7:0]  r_attr_reg;

  // Fill engine context, latched when a fill starts
  logic [7:0]  r_fill_char;
  logic [7:0]  r_fill_attr;
  logic [4:0]  r_row;
  logic [4:0]  r_row_end;
  logic [6:0]  r_col;

  // Registered outputs
  logic [11:0] r_mem_addr;
  logic        r_mem_en;
  logic [15:0] r_mem_data;
  logic [7:0]  r_read_data;

  // Decode and arbitration
  logic        w_char_wr;
  logic        w_row_wr;
  logic        w_attr_wr;
  logic        w_full_cmd;
  logic        w_row_cmd;
  logic        w_fill_start;
  logic        w_busy;
  logic        w_fill_issue;
  logic        w_col_last;
  logic        w_fill_done;

  // Port decode: the low half of the port space is the character window.
  always_comb begin
    w_char_wr  = write_strobe & ~port_id[7];
    w_row_wr   = write_strobe & (port_id == PortRow);
    w_attr_wr  = write_strobe & (port_id == PortAttr);
    w_full_cmd = write_strobe & (port_id == PortFullFill);
    w_row_cmd  = write_strobe & (port_id == PortRowFill);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: fill commands only start a fill from idle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_full_cmd || w_row_cmd) begin
          w_state_next = StFill;
        end
      end
      StFill: begin
        if (w_fill_done) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: the engine issues only in cycles the CPU leaves the port free.
  always_comb begin
    w_busy       = 1'b0;
    w_fill_start = 1'b0;
    w_fill_issue = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_fill_start = w_full_cmd | w_row_cmd;
      end
      StFill: begin
        w_busy       = 1'b1;
        w_fill_issue = ~w_char_wr;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Fill termination: last column of the last row issued this cycle.
  always_comb begin
    w_col_last  = (r_col == ColLast);
    w_fill_done = w_fill_issue & w_col_last & (r_row == r_row_end);
  end

  // Row and attribute registers; writes during a fill affect only later CPU writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_reg  <= 5'd0;
      r_attr_reg <= ATTR_DEFAULT;
    end else begin
      if (w_row_wr) begin
        r_row_reg <= write_data[4:0];
      end
      if (w_attr_wr) begin
        r_attr_reg <= write_data;
      end
    end
  end

  // Fill engine counters: latch extent on start, advance only on an issued write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill_char <= 8'h00;
      r_fill_attr <= 8'h00;
      r_row       <= 5'd0;
      r_row_end   <= 5'd0;
      r_col       <= 7'd0;
    end else if (w_fill_start) begin
      r_fill_char <= write_data;
      r_fill_attr <= r_attr_reg;
      r_col       <= 7'd0;
      if (w_full_cmd) begin
        r_row     <= 5'd0;
        r_row_end <= RowLast;
      end else begin
        r_row     <= r_row_reg;
        r_row_end <= r_row_reg;
      end
    end else if (w_fill_issue) begin
      if (w_col_last) begin
        r_col <= 7'd0;
        r_row <= r_row + 5'd1;
      end else begin
        r_col <= r_col + 7'd1;
      end
    end
  end

  // Memory write port: CPU character write has priority over the fill engine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_en   <= 1'b0;
      r_mem_addr <= 12'h000;
      r_mem_data <= 16'h0000;
    end else if (w_char_wr) begin
      r_mem_en   <= 1'b1;
      r_mem_addr <= {r_row_reg, port_id[6:0]};
      r_mem_data <= {r_attr_reg, write_data};
    end else if (w_fill_issue) begin
      r_mem_en   <= 1'b1;
      r_mem_addr <= {r_row, r_col};
      r_mem_data <= {r_fill_attr, r_fill_char};
    end else begin
      r_mem_en   <= 1'b0;
    end
  end

  // Status read-back: busy flag visible on the full-fill port, zero elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data <= 8'h00;
    end else if (port_id == PortFullFill) begin
      r_read_data <= {7'b0, w_busy};
    end else begin
      r_read_data <= 8'h00;
    end
  end

  assign read_data = r_read_data;
  assign mem_addr  = r_mem_addr;
  assign mem_en    = r_mem_en;
  assign mem_wr    = 1'b1;
  assign mem_data  = r_mem_data;
  assign busy      = w_busy;

endmodule

// File: tb/tb_display_write_controller.sv
// Self-checking bench for display_write_controller with a write-sequence model.
module tb_display_write_controller;

  localparam int ROWS = 30;
  localparam int COLS = 80;
  localparam int W    = ROWS * COLS;

  logic        clk;
  logic        reset;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic [11:0] mem_addr;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  display_write_controller #(
    .ROW_COUNT    (ROWS),
    .COL_COUNT    (COLS),
    .ATTR_DEFAULT (8'h0F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .write_data   (write_data),
    .read_data    (read_data),
    .mem_addr     (mem_addr),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_data     (mem_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k-th write of a fill that starts at start_row, in raster order
  function automatic logic [11:0] fill_addr(input int start_row, input int k);
    int r;
    int c;
    r = start_row + k / COLS;
    c = k % COLS;
    return {r[4:0], c[6:0]};
  endfunction

  // One bus cycle: drive at the falling edge, return at the next falling edge
  task automatic step(input logic s, input logic [7:0] p, input logic [7:0] d);
    write_strobe = s;
    port_id      = p;
    write_data   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    write_strobe = 1'b0;
    port_id      = 8'h00;
    write_data   = 8'h00;
    reset        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", mem_en); end
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL rst_addr got %h exp 000", mem_addr); end
    checks++; if (mem_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", mem_data); end
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL rst_rd got %h exp 00", read_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rst_wr got %b exp 1", mem_wr); end
    reset = 1'b1;
    step(1'b0, 8'h82, 8'h00);
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL rel_rd got %h exp 00", read_data); end
    checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rel_idle got busy=%b en=%b exp 0 0", busy, mem_en); end
  endtask

  task automatic test_char_write();
    logic [4:0]  row_m;
    logic [7:0]  attr_m;
    logic [7:0]  p;
    logic [7:0]  d;
    logic        exp_en;
    logic [11:0] exp_addr;
    logic [15:0] exp_data;
    int          kind;
    do_reset();
    step(1'b1, 8'h80, 8'h05);
    step(1'b1, 8'h81, 8'h1E);
    step(1'b1, 8'h07, 8'h41);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL chr_en got %b exp 1", mem_en); end
    checks++; if (mem_addr !== 12'h287) begin errors++; $display("FAIL chr_addr got %h exp 287", mem_addr); end
    checks++; if (mem_data !== 16'h1E41) begin errors++; $display("FAIL chr_data got %h exp 1E41", mem_data); end
    step(1'b0, 8'h00, 8'h00);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL chr_idle got %b exp 0", mem_en); end
    row_m  = 5'd5;
    attr_m = 8'h1E;
    for (int i = 0; i < 40; i++) begin
      kind   = int'($urandom_range(0, 3));
      d      = 8'($urandom);
      exp_en = 1'b0;
      unique case (kind)
        0: p = 8'h80;
        1: p = 8'h81;
        2: p = 8'($urandom_range(0, 127));
        default: p = 8'($urandom_range(8'h84, 8'hFF));
      endcase
      if (kind == 2) begin
        exp_en   = 1'b1;
        exp_addr = {row_m, p[6:0]};
        exp_data = {attr_m, d};
      end
      step(1'b1, p, d);
      if (kind == 0) row_m = d[4:0];
      if (kind == 1) attr_m = d;
      checks++; if (mem_en !== exp_en) begin errors++; $display("FAIL rnd_en i=%0d got %b exp %b", i, mem_en, exp_en); end
      if (exp_en) begin
        checks++; if (mem_addr !== exp_addr || mem_data !== exp_data)
          begin errors++; $display("FAIL rnd_wr i=%0d got %h/%h exp %h/%h", i, mem_addr, mem_data, exp_addr, exp_data); end
      end
      checks++; if (busy !== 1'b0 || read_data !== 8'h00) begin errors++; $display("FAIL rnd_idle i=%0d got busy=%b rd=%h exp 0 00", i, busy, read_data); end
    end
  endtask

  task automatic test_full_fill();
    int   busy_cnt;
    int   en_cnt;
    logic exp_en;
    logic exp_busy;
    logic [7:0] exp_rd;
    do_reset();
    busy_cnt = 0;
    en_cnt   = 0;
    for (int j = 0; j <= W + 3; j++) begin
      if (j == 0) step(1'b1, 8'h82, 8'h20);
      else        step(1'b0, 8'h82, 8'h00);
      exp_busy = (j < W);
      exp_en   = (j >= 1) && (j <= W);
      exp_rd   = exp_en ? 8'h01 : 8'h00;
      if (busy === 1'b1) busy_cnt++;
      if (mem_en === 1'b1) en_cnt++;
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL ff_busy j=%0d got %b exp %b", j, busy, exp_busy); end
      checks++; if (mem_en !== exp_en) begin errors++; $display("FAIL ff_en j=%0d got %b exp %b", j, mem_en, exp_en); end
      checks++; if (read_data !== exp_rd) begin errors++; $display("FAIL ff_rd j=%0d got %h exp %h", j, read_data, exp_rd); end
      if (exp_en) begin
        checks++; if (mem_addr !== fill_addr(0, j - 1) || mem_data !== 16'h0F20)
          begin errors++; $display("FAIL ff_wr j=%0d got %h/%h exp %h/0F20", j, mem_addr, mem_data, fill_addr(0, j - 1)); end
      end
      if (j == W) begin
        checks++; if (mem_addr !== {5'd29, 7'd79}) begin errors++; $display("FAIL ff_last got %h exp %h", mem_addr, {5'd29, 7'd79}); end
      end
    end
    checks++; if (busy_cnt != W) begin errors++; $display("FAIL ff_busy_cnt got %0d exp %0d", busy_cnt, W); end
    checks++; if (en_cnt != W) begin errors++; $display("FAIL ff_en_cnt got %0d exp %0d", en_cnt, W); end
  endtask

  task automatic test_row_fill();
    logic [4:0] r;
    logic [7:0] a;
    logic [7:0] c;
    logic       exp_en;
    logic       exp_busy;
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      if (rep == 0) begin
        r = 5'd3; a = 8'h0F; c = 8'h2A;
      end else begin
        r = 5'($urandom_range(0, 31)); a = 8'($urandom); c = 8'($urandom);
        step(1'b1, 8'h81, a);
      end
      step(1'b1, 8'h80, {3'b0, r});
      for (int j = 0; j <= COLS + 2; j++) begin
        if (j == 0) step(1'b1, 8'h83, c);
        else        step(1'b0, 8'h00, 8'h00);
        exp_busy = (j < COLS);
        exp_en   = (j >= 1) && (j <= COLS);
        checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rf_busy rep=%0d j=%0d got %b exp %b", rep, j, busy, exp_busy); end
        checks++; if (mem_en !== exp_en) begin errors++; $display("FAIL rf_en rep=%0d j=%0d got %b exp %b", rep, j, mem_en, exp_en); end
        if (exp_en) begin
          checks++; if (mem_addr !== fill_addr(int'(r), j - 1) || mem_data !== {a, c})
            begin errors++; $display("FAIL rf_wr rep=%0d j=%0d got %h/%h exp %h/%h", rep, j, mem_addr, mem_data, fill_addr(int'(r), j - 1), {a, c}); end
        end
      end
    end
  endtask

  task automatic test_fill_contention();
    int          cpu_j [3];
    int          k;
    int          busy_cnt;
    int          en_cnt;
    logic        busy_m;
    logic        is_cpu;
    logic [7:0]  attr_m;
    logic [7:0]  ch;
    logic        exp_en;
    logic [11:0] exp_addr;
    logic [15:0] exp_data;
    do_reset();
    cpu_j[0] = int'($urandom_range(200, 400));
    cpu_j[1] = int'($urandom_range(800, 1000));
    cpu_j[2] = int'($urandom_range(1200, 1400));
    k = 0; busy_cnt = 0; en_cnt = 0; busy_m = 1'b0; attr_m = 8'h0F;
    for (int j = 0; j < 3000; j++) begin
      is_cpu   = (j == cpu_j[0]) || (j == cpu_j[1]) || (j == cpu_j[2]);
      ch       = 8'($urandom);
      exp_en   = 1'b0;
      exp_addr = 12'h000;
      exp_data = 16'h0000;
      if (is_cpu) begin
        exp_en   = 1'b1;
        exp_addr = 12'h010;
        exp_data = {attr_m, ch};
      end else if (busy_m) begin
        exp_en   = 1'b1;
        exp_addr = fill_addr(0, k);
        exp_data = 16'h0F20;
        k++;
        if (k == W) busy_m = 1'b0;
      end
      if (j == 0)        step(1'b1, 8'h82, 8'h20);
      else if (is_cpu)   step(1'b1, 8'h10, ch);
      else if (j == 500) step(1'b1, 8'h82, 8'h55);
      else if (j == 700) step(1'b1, 8'h81, 8'h70);
      else               step(1'b0, 8'h00, 8'h00);
      if (j == 0) busy_m = 1'b1;
      if (j == 700) attr_m = 8'h70;
      if (busy === 1'b1) busy_cnt++;
      if (mem_en === 1'b1) en_cnt++;
      checks++; if (mem_en !== exp_en) begin errors++; $display("FAIL ct_en j=%0d got %b exp %b", j, mem_en, exp_en); end
      if (exp_en) begin
        checks++; if (mem_addr !== exp_addr || mem_data !== exp_data)
          begin errors++; $display("FAIL ct_wr j=%0d got %h/%h exp %h/%h", j, mem_addr, mem_data, exp_addr, exp_data); end
      end
      checks++; if (busy !== busy_m) begin errors++; $display("FAIL ct_busy j=%0d got %b exp %b", j, busy, busy_m); end
      if (j > 0 && !busy_m) break;
    end
    checks++; if (busy_cnt != W + 3) begin errors++; $display("FAIL ct_busy_cnt got %0d exp %0d", busy_cnt, W + 3); end
    checks++; if (en_cnt != W + 3) begin errors++; $display("FAIL ct_en_cnt got %0d exp %0d", en_cnt, W + 3); end
    step(1'b1, 8'h22, 8'h5A);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 12'h022 || mem_data !== 16'h705A)
      begin errors++; $display("FAIL ct_attr got %b/%h/%h exp 1/022/705A", mem_en, mem_addr, mem_data); end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    do_reset();
    step(1'b1, 8'h82, 8'h20);
    n = 0;
    for (int j = 0; j < 300 && n < 100; j++) begin
      step(1'b0, 8'h00, 8'h00);
      if (mem_en === 1'b1) n++;
    end
    checks++; if (n != 100) begin errors++; $display("FAIL rm_reach got %0d exp 100", n); end
    reset = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async got en=%b busy=%b exp 0 0", mem_en, busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 50; j++) begin
      step(1'b0, 8'h00, 8'h00);
      checks++; if (mem_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_noresume j=%0d got en=%b busy=%b exp 0 0", j, mem_en, busy); end
    end
    step(1'b1, 8'h05, 8'h33);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 12'h005 || mem_data !== 16'h0F33)
      begin errors++; $display("FAIL rm_regs got %b/%h/%h exp 1/005/0F33", mem_en, mem_addr, mem_data); end
  endtask

  initial begin
    reset        = 1'b0;
    write_strobe = 1'b0;
    port_id      = 8'h00;
    write_data   = 8'h00;
    test_reset();
    test_char_write();
    test_full_fill();
    test_row_fill();
    test_fill_contention();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
